// File: rtl/preg_free_list_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : preg_free_list_if
//  Purpose  : Bundle of allocation, free and status signals between the
//             physical-register free list and its clients (rename / retire).
//  Ports    : i_alloc_req  - per-lane allocation request (bit0 = slot 0)
//             o_alloc_ok   - every requested lane can be served this cycle
//             o_alloc_preg - granted PReg per lane
//             i_free_valid - per-lane free strobe from retire
//             i_free_preg  - PReg being returned per lane
//             o_free_count - entries currently in the list
//             o_empty      - list is empty
//             o_error      - sticky overflow / illegal-free flag
//  Revision : 1.0 - initial release
// ============================================================================
interface preg_free_list_if #(
    parameter int PW = 7,
    parameter int CW = 7
);
    logic [1:0]         i_alloc_req;
    logic               o_alloc_ok;
    logic [1:0][PW-1:0] o_alloc_preg;
    logic [1:0]         i_free_valid;
    logic [1:0][PW-1:0] i_free_preg;
    logic [CW-1:0]      o_free_count;
    logic               o_empty;
    logic               o_error;

    // Free-list side
    modport slave (
        input  i_alloc_req,
        input  i_free_valid,
        input  i_free_preg,
        output o_alloc_ok,
        output o_alloc_preg,
        output o_free_count,
        output o_empty,
        output o_error
    );

    // Rename / retire side
    modport master (
        output i_alloc_req,
        output i_free_valid,
        output i_free_preg,
        input  o_alloc_ok,
        input  o_alloc_preg,
        input  o_free_count,
        input  o_empty,
        input  o_error
    );
endinterface
`default_nettype wire

// File: rtl/preg_free_list.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : preg_free_list
//  Purpose  : Circular FIFO of free physical-register indices. Grants up to
//             two PRegs per cycle to rename and accepts up to two returned
//             PRegs per cycle from retire.
//  Ports    : i_clk  - clock
//             i_rst  - synchronous active-high reset (restores full list)
//             bus    - preg_free_list_if.slave (alloc / free / status)
//  Revision : 1.0 - initial release
// ============================================================================
module preg_free_list #(
    parameter int NUM_PREGS = 128,
    parameter int NUM_AREGS = 32,
    parameter int DEPTH     = NUM_PREGS - NUM_AREGS,
    parameter int PW        = $clog2(NUM_PREGS)
) (
    input  wire logic          i_clk,
    input  wire logic          i_rst,
    preg_free_list_if.slave    bus
);

    localparam int CW   = $clog2(DEPTH + 1);
    localparam int PTRW = $clog2(DEPTH);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [PW-1:0]   fifo_q [DEPTH];
    logic [PTRW-1:0] head_q, head_d;
    logic [PTRW-1:0] tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            error_q, error_d;

    // Pointer advance with explicit wrap: DEPTH need not be a power of two.
    function automatic logic [PTRW-1:0] wrap_add(input logic [PTRW-1:0] ptr,
                                                 input logic [1:0]      n);
        logic [PTRW:0] s;
        s = {1'b0, ptr} + (PTRW+1)'(n);
        if (s >= (PTRW+1)'(DEPTH)) begin
            s = s - (PTRW+1)'(DEPTH);
        end
        return s[PTRW-1:0];
    endfunction

    // ------------------------------------------------------------------------
    // Allocation: combinational peek at head, pop at the edge
    // ------------------------------------------------------------------------
    logic [1:0]      w_need;
    logic            w_alloc_ok;
    logic [1:0]      w_pops;
    logic [PTRW-1:0] w_head_p1;

    always_comb begin
        w_need     = {1'b0, bus.i_alloc_req[0]} + {1'b0, bus.i_alloc_req[1]};
        w_alloc_ok = (count_q >= CW'(w_need));
        w_pops     = w_alloc_ok ? w_need : 2'd0;
        w_head_p1  = wrap_add(head_q, 2'd1);
    end

    assign bus.o_alloc_ok      = w_alloc_ok;
    assign bus.o_alloc_preg[0] = fifo_q[head_q];
    // Lane 1 takes the second entry only when lane 0 consumes the first.
    assign bus.o_alloc_preg[1] = bus.i_alloc_req[0] ? fifo_q[w_head_p1]
                                                    : fifo_q[head_q];

    // ------------------------------------------------------------------------
    // Free: classify each lane, then admit in lane order against free room
    // ------------------------------------------------------------------------
    logic [1:0]      w_legal;
    logic [1:0]      w_illegal;
    logic [1:0]      w_accept;
    logic [1:0]      w_pushes;
    logic [CW-1:0]   w_after_pop;
    logic [CW-1:0]   w_room;
    logic            w_overflow;
    logic [PTRW-1:0] w_wr_idx1;

    always_comb begin
        for (int l = 0; l < 2; l++) begin
            // PReg 0 is the "no destination" marker and is silently ignored.
            w_illegal[l] = bus.i_free_valid[l] &&
                           (32'(bus.i_free_preg[l]) >= NUM_PREGS);
            w_legal[l]   = bus.i_free_valid[l] &&
                           (bus.i_free_preg[l] != '0) && !w_illegal[l];
        end

        // Room is measured after this cycle's pops, so a simultaneous
        // pop makes space for a push even when the list starts full.
        w_after_pop = count_q - CW'(w_pops);
        w_room      = CW'(DEPTH) - w_after_pop;

        w_accept[0] = w_legal[0] && (w_room >= CW'(1));
        w_accept[1] = w_legal[1] &&
                      (w_room >= (w_accept[0] ? CW'(2) : CW'(1)));

        w_overflow  = (w_legal[0] && !w_accept[0]) ||
                      (w_legal[1] && !w_accept[1]);

        w_pushes    = {1'b0, w_accept[0]} + {1'b0, w_accept[1]};
        w_wr_idx1   = w_accept[0] ? wrap_add(tail_q, 2'd1) : tail_q;

        head_d      = wrap_add(head_q, w_pops);
        tail_d      = wrap_add(tail_q, w_pushes);
        // Cannot exceed DEPTH: pushes are limited to the available room.
        count_d     = w_after_pop + CW'(w_pushes);
        error_d     = error_q || w_overflow || (|w_illegal);
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= CW'(DEPTH);
            error_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            error_q <= error_d;
        end
    end

    // List starts full with every PReg that is not architecturally mapped.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                fifo_q[k] <= PW'(NUM_AREGS + k);
            end
        end else begin
            if (w_accept[0]) begin
                fifo_q[tail_q] <= bus.i_free_preg[0];
            end
            if (w_accept[1]) begin
                fifo_q[w_wr_idx1] <= bus.i_free_preg[1];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Status outputs (registered count)
    // ------------------------------------------------------------------------
    assign bus.o_free_count = count_q;
    assign bus.o_empty      = (count_q == '0);
    assign bus.o_error      = error_q;

endmodule
`default_nettype wire

// File: tb/tb_preg_free_list.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_preg_free_list
//  Purpose  : Self-checking bench for preg_free_list. A queue-based model of
//             the free list predicts each cycle's outputs; a monitor compares
//             them against the DUT on the falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_preg_free_list;

    localparam int NUM_PREGS = 128;
    localparam int NUM_AREGS = 32;
    localparam int DEPTH     = NUM_PREGS - NUM_AREGS;
    localparam int PW        = $clog2(NUM_PREGS);
    localparam int CW        = $clog2(DEPTH + 1);

    logic clk;
    logic rst;

    preg_free_list_if #(.PW(PW), .CW(CW)) bif ();

    preg_free_list #(
        .NUM_PREGS (NUM_PREGS),
        .NUM_AREGS (NUM_AREGS),
        .DEPTH     (DEPTH),
        .PW        (PW)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------------
    // Reference model: plain queue of free PRegs plus a sticky error flag
    // ------------------------------------------------------------------------
    int   fl[$];
    logic m_err;
    logic m_valid;

    typedef struct {
        logic [1:0] req;
        logic       ok;
        int         p0;
        int         p1;
        int         cnt;
        logic       err;
    } exp_t;

    exp_t sb[$];

    int checks;
    int failures;

    task automatic model_reset();
        fl = {};
        for (int p = NUM_AREGS; p < NUM_PREGS; p++) fl.push_back(p);
        m_err   = 1'b0;
        m_valid = 1'b1;
    endtask

    // One clock of stimulus: drive, predict, then advance the model.
    task automatic step(input logic r, input logic [1:0] req,
                        input logic [1:0] fv, input int f0, input int f1);
        exp_t e;
        int   need;
        int   fp[2];
        @(posedge clk);
        #1;
        rst                 = r;
        bif.i_alloc_req     = req;
        bif.i_free_valid    = fv;
        bif.i_free_preg[0]  = PW'(f0);
        bif.i_free_preg[1]  = PW'(f1);

        need = int'(req[0]) + int'(req[1]);
        if (m_valid) begin
            e.req = req;
            e.ok  = (fl.size() >= need);
            e.p0  = (fl.size() > 0) ? fl[0] : -1;
            e.p1  = (need == 2 && fl.size() > 1) ? fl[1] : e.p0;
            e.cnt = fl.size();
            e.err = m_err;
            sb.push_back(e);
        end

        if (r) begin
            model_reset();
        end else if (m_valid) begin
            if (fl.size() >= need) begin
                for (int i = 0; i < need; i++) void'(fl.pop_front());
            end
            fp[0] = f0;
            fp[1] = f1;
            for (int l = 0; l < 2; l++) begin
                if (fv[l] && fp[l] != 0) begin
                    if (fp[l] >= NUM_PREGS) m_err = 1'b1;
                    else if (fl.size() < DEPTH) fl.push_back(fp[l]);
                    else m_err = 1'b1;
                end
            end
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------------
    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("alloc_ok",   int'(bif.o_alloc_ok),   int'(e.ok));
            chk("free_count", int'(bif.o_free_count), e.cnt);
            chk("empty",      int'(bif.o_empty),      int'(e.cnt == 0));
            chk("error",      int'(bif.o_error),      int'(e.err));
            if (e.ok && e.req[0]) chk("preg_lane0", int'(bif.o_alloc_preg[0]), e.p0);
            if (e.ok && e.req[1]) chk("preg_lane1", int'(bif.o_alloc_preg[1]), e.p1);
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int f;
        checks   = 0;
        failures = 0;
        m_valid  = 1'b0;
        m_err    = 1'b0;
        rst                = 1'b1;
        bif.i_alloc_req    = '0;
        bif.i_free_valid   = '0;
        bif.i_free_preg[0] = '0;
        bif.i_free_preg[1] = '0;

        // Full drain with dual requests: 32..127 in order, count 96 -> 0
        step(1'b1, 2'b00, 2'b00, 0, 0);
        for (int i = 0; i < 48; i++) step(1'b0, 2'b11, 2'b00, 0, 0);
        step(1'b0, 2'b11, 2'b00, 0, 0);       // empty: denied

        // Drain to one entry, dual request denied, lane-1-only granted
        step(1'b1, 2'b00, 2'b00, 0, 0);
        for (int i = 0; i < 47; i++) step(1'b0, 2'b11, 2'b00, 0, 0);
        step(1'b0, 2'b01, 2'b00, 0, 0);
        step(1'b0, 2'b11, 2'b00, 0, 0);
        step(1'b0, 2'b10, 2'b00, 0, 0);

        // Empty list: free 40/41 with a same-cycle request (no bypass)
        step(1'b0, 2'b01, 2'b11, 40, 41);
        step(1'b0, 2'b01, 2'b00, 0, 0);
        step(1'b0, 2'b01, 2'b00, 0, 0);

        // Wrap: head at 95, then steady free-2 / alloc-2
        step(1'b1, 2'b00, 2'b00, 0, 0);
        for (int i = 0; i < 47; i++) step(1'b0, 2'b11, 2'b00, 0, 0);
        step(1'b0, 2'b01, 2'b00, 0, 0);
        step(1'b0, 2'b00, 2'b11, 1, 2);
        for (int i = 0; i < 100; i++) begin
            f = 3 + ((2 * i) % 124);
            step(1'b0, 2'b11, 2'b11, f, f + 1);
        end

        // Free of PReg 0 on lane 0 is ignored, lane 1 pushes 55
        step(1'b0, 2'b00, 2'b11, 0, 55);
        step(1'b0, 2'b00, 2'b00, 0, 0);

        // Overflow from full, then reset mid-drain
        step(1'b1, 2'b00, 2'b00, 0, 0);
        step(1'b0, 2'b00, 2'b01, 60, 0);
        step(1'b0, 2'b11, 2'b00, 0, 0);
        for (int i = 0; i < 10; i++) step(1'b0, 2'b11, 2'b00, 0, 0);
        step(1'b1, 2'b11, 2'b11, 5, 6);
        step(1'b0, 2'b01, 2'b00, 0, 0);
        step(1'b0, 2'b00, 2'b00, 0, 0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            logic       r;
            logic [1:0] rq;
            logic [1:0] fv;
            int         a;
            int         b;
            r  = ($urandom_range(0, 299) == 0);
            rq = 2'($urandom);
            fv = 2'($urandom);
            a  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, NUM_PREGS - 1);
            b  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, NUM_PREGS - 1);
            step(r, rq, fv, a, b);
        end

        step(1'b0, 2'b00, 2'b00, 0, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/preg_free_list.md
Name: preg_free_list

Overview:
- Free-list manager for the physical register file.
- Hands out up to two free physical registers per cycle to the two rename slots.
- Accepts up to two retired physical registers per cycle from retire.
- Sits between RENAME (the consumer of allocations) and retire (the producer of frees), and replaces the ad-hoc free-pool scan with a circular FIFO of PReg indices.

Parameters:
- NUM_PREGS, 128, total physical registers.
- NUM_AREGS, 32, architectural registers. PRegs 0..NUM_AREGS-1 are mapped at reset and are never in the list initially.
- DEPTH, NUM_PREGS-NUM_AREGS (96), FIFO capacity.
- PW, $clog2(NUM_PREGS) (7), PReg index width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_alloc_req  in  2  per-lane allocation request. Bit0 is issue slot 0, bit1 is issue slot 1.
- o_alloc_ok  out  1  all requested lanes can be satisfied this cycle.
- o_alloc_preg  out  2xPW  granted PReg per lane. Valid when o_alloc_ok and the lane's request bit are both 1.
- i_free_valid  in  2  per-lane free strobe from retire.
- i_free_preg  in  2xPW  PReg being returned per lane.
- o_free_count  out  $clog2(DEPTH+1)  entries currently in the list.
- o_empty  out  1  o_free_count==0.
- o_error  out  1  sticky: overflow or illegal free detected.

Behaviour:
- Storage:
  - fifo[0..DEPTH-1] holds PW-bit entries.
  - head and tail pointers wrap modulo DEPTH. DEPTH is not a power of two, so wrap is an explicit compare, not bit truncation.
  - count is held in a register.
- Reset (i_rst=1 at posedge):
  - fifo[k]=NUM_AREGS+k.
  - head=0, tail=0 (full), count=DEPTH, o_error=0.
- Reset outputs: o_free_count=96, o_empty=0, o_alloc_ok=1 for any request.
- Reset has priority over all same-cycle requests and frees. Mid-operation reset discards all in-flight state and restores the full list.
- Allocation is combinational peek, popped at the edge:
  - need = popcount(i_alloc_req).
  - o_alloc_ok = (count >= need). need=0 gives o_alloc_ok=1.
  - Lane 0 gets fifo[head] if requesting.
  - Lane 1 gets fifo[head+1] if lane 0 is also requesting, otherwise fifo[head].
  - Grant is all-or-nothing: if o_alloc_ok=0, nothing is popped. The caller stalls both slots and retries.
  - On grant, head advances by need with wrap (94+2 -> 0, 95+1 -> 0, 95+2 -> 1).
  - o_alloc_preg for non-requesting lanes and for denied cycles is don't-care. The bench must not check it.
- Free:
  - A lane is a legal free when i_free_valid is set and i_free_preg != 0. Free of PReg 0 is ignored silently (no-dest convention).
  - Legal frees write at tail. Lane 0 writes first, then lane 1.
  - tail advances by the number of legal frees, with wrap.
  - Freed entries become allocatable the next cycle only. There is no same-cycle bypass, so o_alloc_ok uses the pre-update count.
- Count update: count_next = count - granted_pops + legal_pushes. A simultaneous alloc and free of equal numbers leaves count unchanged.
- Overflow:
  - If count - pops + pushes would exceed DEPTH, excess pushes are dropped. Lane 1 is dropped first.
  - count saturates at DEPTH and o_error sets.
- Illegal free: i_free_preg >= NUM_PREGS sets o_error and the entry is dropped.
- o_error stays set until reset.
- No assertion checks for duplicate frees. That is the retire side's responsibility.
- o_free_count and o_empty reflect registered count, updated one cycle after the event.

Test Plan:
- Reset, then hold i_alloc_req=2'b11 for 48 cycles:
  - PRegs 32,33,...,127 are granted in order, lane 0 even-offset and lane 1 odd-offset.
  - o_free_count steps 96 -> 0.
  - o_empty=1 after the 48th edge.
- Drain to count=1, then request 2'b11:
  - o_alloc_ok=0, no pop, count stays 1.
  - Next request 2'b10 is granted with the remaining PReg 127 on lane 1.
- At count=0, free PRegs 40 and 41 with alloc req 2'b01 in the same cycle:
  - o_alloc_ok=0 in that cycle.
  - Next cycle count=2, and req 2'b01 grants 40.
- Wrap: drive head to 95, then free 2 and allocate 2 repeatedly for 100 cycles:
  - Grants are 127, then the first freed entries in FIFO order.
  - head wraps 95 -> 1, and count stays constant.
- Free with i_free_valid=2'b11, i_free_preg={0,55} (lane 0 = 0, lane 1 = 55):
  - Only 55 is pushed, count increases by 1, o_error=0.
- Overflow and reset:
  - From reset (full), free 60 -> o_error=1 and count stays 96.
  - Assert i_rst mid-drain -> count=96, head=0, o_error=0, first grant 32.
